sprite_scheduler: RTL and testbench

- Shares one 8x16, 24-bit sprite_bitmap lookup between NUM_SPRITES on-screen sprite instances.
- For each pixel from the video timing generator: tests every enabled sprite's bounding box and selects the highest-priority hit. Drives the bitmap row/column offsets, applies chroma-key transparency over the supplied background colour, and emits the final pixel.
- Sprite positions are written through a config port into shadow registers and applied atomically at frame start.

---
 rtl/sprite_scheduler.sv | 163 ++++++++++++++++
 tb/tb_sprite_scheduler.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_scheduler.sv
// Sprite scheduler: tests every enabled sprite box per pixel, picks the lowest-index hit,
// addresses a shared bitmap and composites the chroma-keyed result over the background.
module sprite_scheduler #(
  parameter int          NUM_SPRITES = 4,
  parameter int          COORD_W     = 10,
  parameter int          SPRITE_W    = 8,
  parameter int          SPRITE_H    = 16,
  parameter logic [23:0] KEY_COLOUR  = 24'hFF00FF
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic               frame_start,
  input  logic               pix_valid,
  input  logic [COORD_W-1:0] pix_x,
  input  logic [COORD_W-1:0] pix_y,
  input  logic [23:0]        bg_colour,
  input  logic               cfg_we,
  input  logic [2:0]         cfg_idx,
  input  logic [COORD_W-1:0] cfg_x,
  input  logic [COORD_W-1:0] cfg_y,
  input  logic               cfg_en,
  output logic [15:0]        bmp_yofs,
  output logic [15:0]        bmp_xofs,
  input  logic [23:0]        bmp_colour,
  output logic               out_valid,
  output logic [23:0]        out_colour,
  output logic               out_hit,
  output logic [2:0]         out_idx,
  output logic               collision
);

  localparam int CW1 = COORD_W + 1;

  logic [COORD_W-1:0] sh_x_q  [NUM_SPRITES];
  logic [COORD_W-1:0] sh_y_q  [NUM_SPRITES];
  logic               sh_en_q [NUM_SPRITES];
  logic [COORD_W-1:0] act_x_q [NUM_SPRITES];
  logic [COORD_W-1:0] act_y_q [NUM_SPRITES];
  logic               act_en_q[NUM_SPRITES];

  logic [CW1-1:0]         dx[NUM_SPRITES];
  logic [CW1-1:0]         dy[NUM_SPRITES];
  logic [NUM_SPRITES-1:0] hit;

  // One extra bit keeps "left of / above the sprite" differences large, so they never look like a hit.
  for (genvar gi = 0; gi < NUM_SPRITES; gi++) begin : g_sprite
    assign dx[gi]  = {1'b0, pix_x} - {1'b0, act_x_q[gi]};
    assign dy[gi]  = {1'b0, pix_y} - {1'b0, act_y_q[gi]};
    assign hit[gi] = act_en_q[gi] && (dx[gi] < CW1'(SPRITE_W)) && (dy[gi] < CW1'(SPRITE_H));

    always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
        sh_x_q[gi]   <= '0;
        sh_y_q[gi]   <= '0;
        sh_en_q[gi]  <= 1'b0;
        act_x_q[gi]  <= '0;
        act_y_q[gi]  <= '0;
        act_en_q[gi] <= 1'b0;
      end else begin
        // Copy sees the pre-write shadow because both are non-blocking updates of the same edge.
        if (frame_start) begin
          act_x_q[gi]  <= sh_x_q[gi];
          act_y_q[gi]  <= sh_y_q[gi];
          act_en_q[gi] <= sh_en_q[gi];
        end
        if (cfg_we && (cfg_idx == 3'(gi))) begin
          sh_x_q[gi]  <= cfg_x;
          sh_y_q[gi]  <= cfg_y;
          sh_en_q[gi] <= cfg_en;
        end
      end
    end
  end

  logic [2:0]     win_idx_d;
  logic [CW1-1:0] win_dx_d;
  logic [CW1-1:0] win_dy_d;
  logic [3:0]     n_hits_d;

  always_comb begin
    win_idx_d = 3'd0;
    win_dx_d  = dx[0];
    win_dy_d  = dy[0];
    n_hits_d  = 4'd0;
    for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
      if (hit[i]) begin
        win_idx_d = 3'(i);
        win_dx_d  = dx[i];
        win_dy_d  = dy[i];
        n_hits_d  = n_hits_d + 4'd1;
      end
    end
  end

  logic        s1_valid_q;
  logic        s1_any_q;
  logic [2:0]  s1_idx_q;
  logic [23:0] s1_bg_q;
  logic [15:0] s1_yofs_q;
  logic [15:0] s1_xofs_q;
  logic        coll_q;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      s1_valid_q <= 1'b0;
      s1_any_q   <= 1'b0;
      s1_idx_q   <= 3'd0;
      s1_bg_q    <= 24'd0;
      s1_yofs_q  <= 16'd0;
      s1_xofs_q  <= 16'd0;
      coll_q     <= 1'b0;
    end else begin
      s1_valid_q <= pix_valid;
      if (pix_valid) begin
        s1_any_q  <= |hit;
        s1_idx_q  <= win_idx_d;
        s1_bg_q   <= bg_colour;
        s1_yofs_q <= 16'(win_dy_d[COORD_W-1:0]);
        s1_xofs_q <= 16'(win_dx_d[COORD_W-1:0]);
      end
      // Frame start has priority so a fresh frame never inherits an overlap.
      if (frame_start) begin
        coll_q <= 1'b0;
      end else if (pix_valid && (n_hits_d >= 4'd2)) begin
        coll_q <= 1'b1;
      end
    end
  end

  assign bmp_yofs = s1_yofs_q;
  assign bmp_xofs = s1_xofs_q;

  logic        opaque;
  logic        out_valid_q;
  logic [23:0] out_colour_q;
  logic        out_hit_q;
  logic [2:0]  out_idx_q;

  assign opaque = s1_any_q && (bmp_colour != KEY_COLOUR);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      out_valid_q  <= 1'b0;
      out_colour_q <= 24'd0;
      out_hit_q    <= 1'b0;
      out_idx_q    <= 3'd0;
    end else begin
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        out_colour_q <= opaque ? bmp_colour : s1_bg_q;
        out_hit_q    <= opaque;
        out_idx_q    <= opaque ? s1_idx_q : 3'd0;
      end
    end
  end

  assign out_valid  = out_valid_q;
  assign out_colour = out_colour_q;
  assign out_hit    = out_hit_q;
  assign out_idx    = out_idx_q;
  assign collision  = coll_q;

endmodule

// File: tb/tb_sprite_scheduler.sv
// Randomised and directed bench for sprite_scheduler against a box-test reference model.
module tb_sprite_scheduler;
  localparam int          N   = 4;
  localparam int          CW  = 10;
  localparam logic [23:0] KEY = 24'hFF00FF;

  logic          clock = 1'b0;
  logic          resetn;
  logic          frame_start, pix_valid, cfg_we, cfg_en;
  logic [CW-1:0] pix_x, pix_y, cfg_x, cfg_y;
  logic [23:0]   bg_colour, bmp_colour, out_colour;
  logic [2:0]    cfg_idx, out_idx;
  logic [15:0]   bmp_yofs, bmp_xofs;
  logic          out_valid, out_hit, collision;

  logic [23:0] bitmap [16][8];
  assign bmp_colour = bitmap[bmp_yofs[3:0]][bmp_xofs[2:0]];

  sprite_scheduler #(.NUM_SPRITES(N), .COORD_W(CW)) dut (
    .clock(clock), .resetn(resetn), .frame_start(frame_start), .pix_valid(pix_valid),
    .pix_x(pix_x), .pix_y(pix_y), .bg_colour(bg_colour), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
    .cfg_x(cfg_x), .cfg_y(cfg_y), .cfg_en(cfg_en), .bmp_yofs(bmp_yofs), .bmp_xofs(bmp_xofs),
    .bmp_colour(bmp_colour), .out_valid(out_valid), .out_colour(out_colour), .out_hit(out_hit),
    .out_idx(out_idx), .collision(collision)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit          v;
    bit          any;
    logic [23:0] col;
    bit          hit;
    logic [2:0]  idx;
    int          yo;
    int          xo;
  } exp_t;

  int          sh_x[N], sh_y[N], act_x[N], act_y[N];
  bit          sh_en[N], act_en[N];
  bit          m_coll;
  exp_t        p1, p2;
  logic [23:0] held_col;
  int          total = 0;
  int          bad = 0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference: plain box containment on integers, first enabled hit wins.
  task automatic model_pixel(input bit pv, input int px, input int py, input logic [23:0] bg,
                             output exp_t e, output int nh);
    int w;
    logic [23:0] c;
    w = -1; nh = 0;
    e.v = pv; e.any = 0; e.hit = 0; e.idx = 0; e.col = bg; e.yo = 0; e.xo = 0;
    for (int s = 0; s < N; s++) begin
      if (act_en[s] && px >= act_x[s] && px < act_x[s] + 8 && py >= act_y[s] && py < act_y[s] + 16) begin
        nh++;
        if (w < 0) w = s;
      end
    end
    if (w >= 0) begin
      e.any = 1;
      e.yo  = py - act_y[w];
      e.xo  = px - act_x[w];
      c     = bitmap[e.yo][e.xo];
      if (c != KEY) begin
        e.hit = 1; e.col = c; e.idx = 3'(w);
      end
    end
  endtask

  task automatic step(input bit fs, input bit pv, input int px, input int py, input logic [23:0] bg,
                      input bit we = 0, input int ci = 0, input int cx = 0, input int cy = 0,
                      input bit ce = 0);
    exp_t e;
    int   nh;
    frame_start = fs; pix_valid = pv; pix_x = CW'(px); pix_y = CW'(py); bg_colour = bg;
    cfg_we = we; cfg_idx = 3'(ci); cfg_x = CW'(cx); cfg_y = CW'(cy); cfg_en = ce;
    model_pixel(pv, px, py, bg, e, nh);
    @(posedge clock); #1;
    if (fs) begin
      act_x = sh_x; act_y = sh_y; act_en = sh_en; m_coll = 0;
    end else if (pv && nh >= 2) begin
      m_coll = 1;
    end
    if (we && ci < N) begin
      sh_x[ci] = cx; sh_y[ci] = cy; sh_en[ci] = ce;
    end
    p2 = p1; p1 = e;
    if (p2.v) held_col = p2.col;
    chk("out_valid", 32'(out_valid), 32'(p2.v));
    chk("out_colour", 32'(out_colour), 32'(held_col));
    if (p2.v) begin
      chk("out_hit", 32'(out_hit), 32'(p2.hit));
      chk("out_idx", 32'(out_idx), 32'(p2.idx));
    end
    chk("collision", 32'(collision), 32'(m_coll));
    if (p1.v && p1.any) begin
      chk("bmp_yofs", 32'(bmp_yofs), 32'(p1.yo));
      chk("bmp_xofs", 32'(bmp_xofs), 32'(p1.xo));
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 24'h0);
  endtask

  task automatic model_reset();
    for (int s = 0; s < N; s++) begin
      sh_x[s] = 0; sh_y[s] = 0; sh_en[s] = 0; act_x[s] = 0; act_y[s] = 0; act_en[s] = 0;
    end
    m_coll = 0; p1 = '{default: 0}; p2 = '{default: 0}; held_col = 24'h0;
  endtask

  initial begin
    resetn = 1'b0;
    frame_start = 0; pix_valid = 0; pix_x = 0; pix_y = 0; bg_colour = 0;
    cfg_we = 0; cfg_idx = 0; cfg_x = 0; cfg_y = 0; cfg_en = 0;
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 8; c++)
        bitmap[r][c] = ($urandom_range(0, 3) == 0) ? KEY : 24'($urandom);
    model_reset();
    #12;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_colour", 32'(out_colour), 32'd0);
    chk("rst_collision", 32'(collision), 32'd0);
    chk("rst_bmp_yofs", 32'(bmp_yofs), 32'd0);
    chk("rst_bmp_xofs", 32'(bmp_xofs), 32'd0);
    resetn = 1'b1;

    // No sprites: background passes through with 2-cycle latency.
    step(1, 0, 0, 0, 0);
    for (int x = 0; x < 16; x++) step(0, 1, x, 0, 24'h123456);
    idle(2);
    chk("bg_stream_colour", 32'(out_colour), 32'h123456);

    // Single sprite, opaque then keyed pixel.
    bitmap[5][3] = 24'hFFFFFF;
    step(0, 0, 0, 0, 0, 1, 0, 100, 50, 1);
    step(1, 0, 0, 0, 0);
    step(0, 1, 103, 55, 24'hABCDEF);
    chk("ofs_y_direct", 32'(bmp_yofs), 32'd5);
    chk("ofs_x_direct", 32'(bmp_xofs), 32'd3);
    idle(1);
    chk("opaque_colour", 32'(out_colour), 32'hFFFFFF);
    chk("opaque_hit", 32'(out_hit), 32'd1);
    idle(1);
    bitmap[5][3] = KEY;
    step(0, 1, 103, 55, 24'hABCDEF);
    idle(2);
    chk("keyed_colour", 32'(out_colour), 32'hABCDEF);
    chk("keyed_hit", 32'(out_hit), 32'd0);

    // Overlap of sprites 1 and 2: lower index wins, collision sticky until frame start.
    bitmap[2][2] = 24'h00AA00;
    step(0, 0, 0, 0, 0, 1, 1, 10, 10, 1);
    step(0, 0, 0, 0, 0, 1, 2, 10, 10, 1);
    step(1, 0, 0, 0, 0);
    step(0, 1, 12, 12, 24'h0);
    idle(3);
    chk("coll_sticky", 32'(collision), 32'd1);
    step(1, 0, 0, 0, 0);

    // Bounding-box edges and no wrap at the screen edge.
    step(0, 1, 99, 50, 24'h111111);
    step(0, 1, 108, 50, 24'h222222);
    step(0, 1, 100, 66, 24'h333333);
    step(0, 0, 0, 0, 0, 1, 3, 0, 0, 1);
    step(1, 0, 0, 0, 0);
    step(0, 1, 1023, 0, 24'h444444);
    idle(2);
    chk("nowrap_hit", 32'(out_hit), 32'd0);

    // Shadow writes take effect only at frame start; a coincident write waits a frame.
    bitmap[5][3] = 24'h0000FF;
    step(0, 0, 0, 0, 0, 1, 0, 200, 50, 1);
    step(0, 1, 103, 55, 24'h555555);
    step(0, 1, 203, 55, 24'h555555);
    step(1, 0, 0, 0, 0);
    step(0, 1, 203, 55, 24'h666666);
    step(1, 0, 0, 0, 0, 1, 0, 300, 50, 1);
    step(0, 1, 303, 55, 24'h777777);
    step(0, 1, 203, 55, 24'h777777);
    step(1, 0, 0, 0, 0);
    step(0, 1, 303, 55, 24'h888888);
    idle(2);

    // Random traffic around a small cluster of sprites, plus the right screen edge.
    for (int i = 0; i < 1500; i++) begin
      bit we, fs, pv, edge_px;
      int cx, px;
      we = ($urandom_range(0, 9) == 0);
      fs = ($urandom_range(0, 39) == 0);
      pv = ($urandom_range(0, 4) != 0);
      edge_px = ($urandom_range(0, 9) == 0);
      cx = edge_px ? $urandom_range(1015, 1023) : $urandom_range(0, 40);
      px = edge_px ? $urandom_range(1016, 1023) : $urandom_range(0, 55);
      step(fs, pv, px, $urandom_range(0, 60), 24'($urandom),
           we, $urandom_range(0, 7), cx, $urandom_range(0, 40), bit'($urandom_range(0, 3) != 0));
    end

    // Reset with pixels in flight and collision set.
    step(0, 0, 0, 0, 0, 1, 1, 20, 20, 1);
    step(0, 0, 0, 0, 0, 1, 2, 20, 20, 1);
    step(1, 0, 0, 0, 0);
    step(0, 1, 21, 21, 24'h0);
    step(0, 1, 22, 22, 24'h0);
    chk("pre_rst_coll", 32'(collision), 32'd1);
    pix_valid = 1'b0;
    #2 resetn = 1'b0;
    #1;
    chk("async_rst_valid", 32'(out_valid), 32'd0);
    chk("async_rst_coll", 32'(collision), 32'd0);
    @(posedge clock); #1;
    resetn = 1'b1;
    model_reset();
    step(1, 0, 0, 0, 0);
    step(0, 1, 21, 21, 24'h999999);
    idle(2);
    chk("post_rst_hit", 32'(out_hit), 32'd0);
    chk("post_rst_colour", 32'(out_colour), 32'h999999);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
